// File: rtl/pic_pkg.sv
// Shared definitions for the 8259-style acknowledge path: IR count, handshake
// states and the fixed-priority (IR0 highest) bit picker.
package pic_pkg;

    localparam int unsigned IR_COUNT = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK1,
        ST_WAIT2,
        ST_ACK2
    } ack_state_t;

    // Lowest set index wins; returns 7 when nothing is set.
    function automatic logic [2:0] highest_priority(input logic [IR_COUNT-1:0] v);
        logic [2:0] idx;
        logic       hit;
        idx = 3'd7;
        hit = 1'b0;
        for (int unsigned i = 0; i < IR_COUNT; i++) begin
            if (v[i] && !hit) begin
                idx = 3'(i);
                hit = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/interrupt_ack_sequencer_if.sv
// Bus between PIC control/request logic (master) and the acknowledge sequencer (slave).
// aeoi_mode exists only when PIC_AEOI_EN is defined.
interface interrupt_ack_sequencer_if;
    import pic_pkg::*;

    logic [IR_COUNT-1:0] interrupt_req_register;
    logic [IR_COUNT-1:0] interrupt_mask;
    logic [4:0]          vector_base;
    logic                inta_n;
    logic                eoi_nonspecific;
    logic                eoi_specific;
    logic [2:0]          eoi_level;
`ifdef PIC_AEOI_EN
    logic                aeoi_mode;
`endif
    logic                int_out;
    logic                freeze;
    logic [IR_COUNT-1:0] clear_interrupt_req;
    logic [IR_COUNT-1:0] in_service_register;
    logic [7:0]          vector_out;
    logic                vector_valid;

    modport master (
`ifdef PIC_AEOI_EN
        output aeoi_mode,
`endif
        output interrupt_req_register, interrupt_mask, vector_base, inta_n,
        output eoi_nonspecific, eoi_specific, eoi_level,
        input  int_out, freeze, clear_interrupt_req, in_service_register,
        input  vector_out, vector_valid
    );

    modport slave (
`ifdef PIC_AEOI_EN
        input  aeoi_mode,
`endif
        input  interrupt_req_register, interrupt_mask, vector_base, inta_n,
        input  eoi_nonspecific, eoi_specific, eoi_level,
        output int_out, freeze, clear_interrupt_req, in_service_register,
        output vector_out, vector_valid
    );

endinterface

// File: rtl/priority_resolver.sv
// Combinational fully-nested priority: highest unmasked request strictly above
// the highest-priority in-service level.
module priority_resolver
    import pic_pkg::*;
(
    input  logic [IR_COUNT-1:0] i_irr,
    input  logic [IR_COUNT-1:0] i_mask,
    input  logic [IR_COUNT-1:0] i_isr,
    output logic                o_found,
    output logic [2:0]          o_level
);

    logic [2:0]          w_isr_top;
    logic [IR_COUNT-1:0] w_allowed;
    logic [IR_COUNT-1:0] w_serviceable;

    always_comb begin
        w_isr_top = highest_priority(i_isr);
        w_allowed = '0;
        for (int unsigned i = 0; i < IR_COUNT; i++) begin
            w_allowed[i] = (i_isr == '0) || (3'(i) < w_isr_top);
        end
        w_serviceable = i_irr & ~i_mask & w_allowed;
    end

    assign o_found = |w_serviceable;
    assign o_level = highest_priority(w_serviceable);

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// 8259-style acknowledge sequencer: raises INT, runs the two-pulse INTA handshake,
// maintains ISR and services EOIs. Define PIC_AEOI_EN for automatic EOI support.
module interrupt_ack_sequencer
    import pic_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    interrupt_ack_sequencer_if.slave   ack_bus
);

    ack_state_t          r_state;
    ack_state_t          w_state_next;
    logic                r_inta_prev;
    logic [2:0]          r_level;
    logic [IR_COUNT-1:0] r_isr;
    logic [IR_COUNT-1:0] r_clear;
    logic                r_int_out;
    logic                r_freeze;
    logic [7:0]          r_vector_out;
    logic                r_vector_valid;
`ifdef PIC_AEOI_EN
    logic                r_spurious;
`endif

    logic                w_fall;
    logic                w_rise;
    logic                w_found;
    logic [2:0]          w_res_level;
    logic                w_ack_start;
    logic                w_vector_load;
    logic                w_ack_done;
    logic [IR_COUNT-1:0] w_isr_clr;
    logic [IR_COUNT-1:0] w_isr_set;
    logic [IR_COUNT-1:0] w_isr_next;

    assign w_fall = !ack_bus.inta_n &&  r_inta_prev;
    assign w_rise =  ack_bus.inta_n && !r_inta_prev;

    priority_resolver u_resolver (
        .i_irr   (ack_bus.interrupt_req_register),
        .i_mask  (ack_bus.interrupt_mask),
        .i_isr   (r_isr),
        .o_found (w_found),
        .o_level (w_res_level)
    );

    always_comb begin
        w_state_next  = r_state;
        w_ack_start   = 1'b0;
        w_vector_load = 1'b0;
        w_ack_done    = 1'b0;
        case (r_state)
            ST_IDLE: if (w_fall) begin
                w_state_next = ST_ACK1;
                w_ack_start  = 1'b1;
            end
            ST_ACK1: if (w_rise) w_state_next = ST_WAIT2;
            ST_WAIT2: if (w_fall) begin
                w_state_next  = ST_ACK2;
                w_vector_load = 1'b1;
            end
            ST_ACK2: if (w_rise) begin
                w_state_next = ST_IDLE;
                w_ack_done   = 1'b1;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // EOI acts on the pre-update ISR; a same-cycle acknowledge set lands on top of the clear.
    always_comb begin
        w_isr_clr = '0;
        w_isr_set = '0;
        if (ack_bus.eoi_specific) begin
            w_isr_clr[ack_bus.eoi_level] = 1'b1;
        end else if (ack_bus.eoi_nonspecific && (r_isr != '0)) begin
            w_isr_clr[highest_priority(r_isr)] = 1'b1;
        end
`ifdef PIC_AEOI_EN
        if (w_ack_done && ack_bus.aeoi_mode && !r_spurious) begin
            w_isr_clr[r_level] = 1'b1;
        end
`endif
        if (w_ack_start && w_found) begin
            w_isr_set[w_res_level] = 1'b1;
        end
        w_isr_next = (r_isr & ~w_isr_clr) | w_isr_set;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_inta_prev    <= 1'b1;
            r_level        <= '0;
            r_isr          <= '0;
            r_clear        <= '0;
            r_int_out      <= 1'b0;
            r_freeze       <= 1'b0;
            r_vector_out   <= '0;
            r_vector_valid <= 1'b0;
`ifdef PIC_AEOI_EN
            r_spurious     <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_inta_prev <= ack_bus.inta_n;
            r_isr       <= w_isr_next;
            r_clear     <= w_isr_set;
            r_int_out   <= (w_state_next == ST_IDLE) && w_found;
            r_freeze    <= (w_state_next != ST_IDLE);
            if (w_ack_start) begin
                r_level    <= w_found ? w_res_level : 3'd7;
`ifdef PIC_AEOI_EN
                r_spurious <= !w_found;
`endif
            end
            if (w_vector_load) begin
                r_vector_out   <= {ack_bus.vector_base, r_level};
                r_vector_valid <= 1'b1;
            end else if (w_ack_done) begin
                r_vector_valid <= 1'b0;
            end
        end
    end

    assign ack_bus.int_out             = r_int_out;
    assign ack_bus.freeze              = r_freeze;
    assign ack_bus.clear_interrupt_req = r_clear;
    assign ack_bus.in_service_register = r_isr;
    assign ack_bus.vector_out          = r_vector_out;
    assign ack_bus.vector_valid        = r_vector_valid;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Bench for interrupt_ack_sequencer: per-cycle comparison against a behavioural
// model plus directed literal expectations.
module tb_interrupt_ack_sequencer;

    localparam int O_INT = 0;
    localparam int O_FRZ = 1;
    localparam int O_CLR = 2;
    localparam int O_ISR = 3;
    localparam int O_VEC = 4;
    localparam int O_VV  = 5;

    typedef struct {
        string      name;
        int         sel;
        logic [7:0] val;
    } pin_t;

    logic clk;
    logic rst_n;
    interrupt_ack_sequencer_if bus_if();

    interrupt_ack_sequencer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ack_bus (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   checks;
    int   failures;
    pin_t pins[$];

    // Behavioural model: handshake phase counts INTA edges seen (0 = idle).
    int         m_phase;
    logic       m_prev;
    logic [7:0] m_isr;
    logic [7:0] m_nisr;
    int         m_level;
    logic       m_spur;
    logic       m_int;
    logic       m_frz;
    logic [7:0] m_clr;
    logic [7:0] m_vec;
    logic       m_vv;
    logic       m_valid = 1'b0;
    int         m_top;
    int         m_cand;
    logic       m_fall;
    logic       m_rise;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0; m_prev = 1'b1; m_isr = 8'h00; m_level = 0; m_spur = 1'b0;
            m_int = 1'b0; m_frz = 1'b0; m_clr = 8'h00; m_vec = 8'h00; m_vv = 1'b0;
        end else begin
            m_fall = m_prev && !bus_if.inta_n;
            m_rise = !m_prev && bus_if.inta_n;
            m_prev = bus_if.inta_n;
            m_top = 8;
            for (int i = 7; i >= 0; i--) if (m_isr[i]) m_top = i;
            m_cand = -1;
            for (int i = m_top - 1; i >= 0; i--)
                if (bus_if.interrupt_req_register[i] && !bus_if.interrupt_mask[i]) m_cand = i;
            m_nisr = m_isr;
            if (bus_if.eoi_specific) m_nisr[bus_if.eoi_level] = 1'b0;
            else if (bus_if.eoi_nonspecific) m_nisr = m_isr & (m_isr - 8'd1);
            m_clr = 8'h00;
            if (m_phase == 0 && m_fall) begin
                m_phase = 1;
                m_spur  = (m_cand < 0);
                m_level = m_spur ? 7 : m_cand;
                if (!m_spur) begin
                    m_nisr[m_level] = 1'b1;
                    m_clr = 8'(1 << m_level);
                end
            end else if (m_phase == 1 && m_rise) begin
                m_phase = 2;
            end else if (m_phase == 2 && m_fall) begin
                m_phase = 3;
                m_vec = bus_if.vector_base * 8'd8 + 8'(m_level);
                m_vv = 1'b1;
            end else if (m_phase == 3 && m_rise) begin
                m_phase = 0;
                m_vv = 1'b0;
`ifdef PIC_AEOI_EN
                if (bus_if.aeoi_mode && !m_spur) m_nisr[m_level] = 1'b0;
`endif
            end
            m_isr = m_nisr;
            m_frz = (m_phase != 0);
            m_int = (m_phase == 0) && (m_cand >= 0);
        end
        m_valid = 1'b1;
    end

    function automatic logic [7:0] dut_out(input int sel);
        case (sel)
            O_INT:   return {7'd0, bus_if.int_out};
            O_FRZ:   return {7'd0, bus_if.freeze};
            O_CLR:   return bus_if.clear_interrupt_req;
            O_ISR:   return bus_if.in_service_register;
            O_VEC:   return bus_if.vector_out;
            default: return {7'd0, bus_if.vector_valid};
        endcase
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%02h expected=%02h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        pin_t p;
        if (m_valid) begin
            chk("int_out",      dut_out(O_INT), {7'd0, m_int});
            chk("freeze",       dut_out(O_FRZ), {7'd0, m_frz});
            chk("clear_req",    dut_out(O_CLR), m_clr);
            chk("isr",          dut_out(O_ISR), m_isr);
            chk("vector_out",   dut_out(O_VEC), m_vec);
            chk("vector_valid", dut_out(O_VV),  {7'd0, m_vv});
        end
        while (pins.size() > 0) begin
            p = pins.pop_front();
            chk(p.name, dut_out(p.sel), p.val);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pin(input string n, input int sel, input logic [7:0] v);
        pin_t p;
        p.name = n; p.sel = sel; p.val = v;
        pins.push_back(p);
    endtask

    task automatic pin_all_zero(input string n);
        for (int s = O_INT; s <= O_VV; s++) pin(n, s, 8'h00);
    endtask

    task automatic ack(input logic [7:0] exp_clr, input logic [7:0] exp_isr, input logic [7:0] exp_vec);
        bus_if.inta_n = 1'b0; step();
        pin("ack1_clear", O_CLR, exp_clr);
        pin("ack1_isr",   O_ISR, exp_isr);
        pin("ack1_freeze", O_FRZ, 8'h01);
        pin("ack1_int",   O_INT, 8'h00);
        bus_if.interrupt_req_register = bus_if.interrupt_req_register & ~exp_clr;
        bus_if.inta_n = 1'b1; step();
        pin("wait2_clear", O_CLR, 8'h00);
        bus_if.inta_n = 1'b0; step();
        pin("ack2_vector", O_VEC, exp_vec);
        pin("ack2_valid",  O_VV,  8'h01);
        bus_if.inta_n = 1'b1; step();
        pin("idle_valid",  O_VV,  8'h00);
        pin("idle_freeze", O_FRZ, 8'h00);
    endtask

    task automatic eoi(input logic spec, input logic ns, input logic [2:0] lvl, input logic [7:0] exp_isr);
        bus_if.eoi_specific = spec; bus_if.eoi_nonspecific = ns; bus_if.eoi_level = lvl;
        step();
        bus_if.eoi_specific = 1'b0; bus_if.eoi_nonspecific = 1'b0;
        pin("eoi_isr", O_ISR, exp_isr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        bus_if.interrupt_req_register = 8'h00;
        bus_if.interrupt_mask = 8'h00;
        bus_if.vector_base = 5'h08;
        bus_if.inta_n = 1'b1;
        bus_if.eoi_nonspecific = 1'b0;
        bus_if.eoi_specific = 1'b0;
        bus_if.eoi_level = 3'd0;
`ifdef PIC_AEOI_EN
        bus_if.aeoi_mode = 1'b0;
`endif
        step(); step(); step();
        pin_all_zero("reset");
        rst_n = 1'b1; step();

        // Basic acknowledge of IR3 out of 0x28
        bus_if.interrupt_req_register = 8'h28; step();
        pin("t1_int", O_INT, 8'h01);
        ack(8'h08, 8'h08, 8'h43);
        eoi(1'b1, 1'b0, 3'd3, 8'h00);

        // Masking
        bus_if.interrupt_req_register = 8'h01; bus_if.interrupt_mask = 8'h01; step(); step();
        pin("t2_masked_int", O_INT, 8'h00);
        bus_if.interrupt_req_register = 8'h03; step();
        pin("t2_int", O_INT, 8'h01);
        ack(8'h02, 8'h02, 8'h41);
        eoi(1'b0, 1'b1, 3'd0, 8'h00);
        bus_if.interrupt_mask = 8'h00; bus_if.interrupt_req_register = 8'h00; step();

        // Nesting below and above an in-service level
        bus_if.interrupt_req_register = 8'h04; step();
        ack(8'h04, 8'h04, 8'h42);
        bus_if.interrupt_req_register = 8'h10; step(); step();
        pin("t3_nested_int", O_INT, 8'h00);
        bus_if.interrupt_req_register = 8'h12; step();
        pin("t3_int", O_INT, 8'h01);
        ack(8'h02, 8'h06, 8'h41);

        // EOI variants on ISR = 0x06
        bus_if.interrupt_req_register = 8'h00;
        eoi(1'b0, 1'b1, 3'd0, 8'h04);
        eoi(1'b1, 1'b0, 3'd2, 8'h00);
        eoi(1'b0, 1'b1, 3'd0, 8'h00);
        bus_if.interrupt_req_register = 8'h04; step();
        ack(8'h04, 8'h04, 8'h42);
        bus_if.interrupt_req_register = 8'h02; step();
        ack(8'h02, 8'h06, 8'h41);
        eoi(1'b1, 1'b1, 3'd1, 8'h04);
        eoi(1'b0, 1'b1, 3'd0, 8'h00);

        // Spurious: request withdrawn before first INTA
        bus_if.interrupt_req_register = 8'h01; step();
        pin("t4_int", O_INT, 8'h01);
        bus_if.interrupt_req_register = 8'h00; step();
        pin("t4_withdrawn_int", O_INT, 8'h00);
        ack(8'h00, 8'h00, 8'h47);

        // Reset in ACK1
        bus_if.interrupt_req_register = 8'h08; step();
        bus_if.inta_n = 1'b0; step();
        pin("t6_freeze", O_FRZ, 8'h01);
        rst_n = 1'b0; step();
        pin_all_zero("t6_reset");
        rst_n = 1'b1; bus_if.inta_n = 1'b1; bus_if.interrupt_req_register = 8'h00;
        step(); step();

`ifdef PIC_AEOI_EN
        bus_if.aeoi_mode = 1'b1;
        bus_if.interrupt_req_register = 8'h08; step();
        ack(8'h08, 8'h08, 8'h43);
        pin("aeoi_isr", O_ISR, 8'h00);
        bus_if.aeoi_mode = 1'b0; step();
`endif

        step(); step();
        @(negedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
